pkt_mux_avlstrm_n: RTL
======================

# pkt_mux_avlstrm_n

Parametrised N-input packet multiplexer for 512-bit Avalon-ST packet streams. It merges NUM_IN input channels onto one output. Arbitration is round-robin and packet-atomic, there is a registered output stage, new-packet gating honours downstream almost-full, and non-SOP orphan beats are drained. It replaces cascaded fixed 3-input muxes in the ethernet egress path, and optionally exports per-channel packet counters for the stats packer.

## Interface
Parameters:
- NUM_IN, 4: number of input channels; legal range 2..16.
- DATA_W, 512: beat width in bits; multiple of 8.
- EMPTY_W (localparam), $clog2(DATA_W/8): width of the empty field.

Ports:
- Clk  in  1  single clock; all logic on its rising edge.
- Rst  in  1  synchronous, active-high reset.
- in_valid  in  NUM_IN  per-channel beat valid.
- in_ready  out  NUM_IN  per-channel beat accept.
- in_data  in  NUM_IN*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W].
- in_sop, in_eop  in  NUM_IN each  per-channel start/end of packet.
- in_empty  in  NUM_IN*EMPTY_W  per-channel empty bytes on the EOP beat.
- out_valid  out  1  output beat valid (registered).
- out_ready  in  1  downstream accept.
- out_data  out  DATA_W  output beat data.
- out_sop, out_eop  out  1 each  output start/end of packet.
- out_empty  out  EMPTY_W  output empty field.
- out_almost_full  in  1  downstream near-full; blocks new grants only.
- stat_in_pkt  out  NUM_IN*32  per-input packets forwarded.
- stat_out_pkt  out  32  packets delivered downstream.
- stat_err  out  32  orphan beats drained.

## Operation
- FSM states: IDLE and BUSY.
- IDLE, grant step:
  - Candidates are channels with in_valid & in_sop.
  - If any candidate exists and out_almost_full=0, the round-robin search picks the winner. Search order is last+1, last+2, … wrapping modulo NUM_IN.
  - The winner is registered as grant, last is set to the winner, and the FSM moves to BUSY.
- IDLE, orphan drain:
  - Channels with in_valid=1 and in_sop=0 get in_ready=1 and their beat is discarded.
  - stat_err increments by 1 per cycle in which any channel is drained.
  - If two or more channels drain in the same cycle, stat_err still increments by only 1.
- BUSY, beat transfer:
  - in_ready[grant] = !out_valid | out_ready.
  - All other in_ready are 0.
  - An accepted beat loads the output register with data, sop, eop and empty, and sets out_valid=1.
- BUSY, end of packet:
  - Acceptance of the beat with in_eop[grant]=1 returns the FSM to IDLE.
  - stat_in_pkt[grant] increments at that acceptance.
- BUSY, protocol errors:
  - A beat with in_sop=1 arriving mid-packet on the granted channel is forwarded unchanged and not checked.
  - out_almost_full is ignored while BUSY; a packet in flight always completes.
- Output register: out_valid clears on out_ready with no new beat loaded.
- stat_out_pkt increments when out_valid & out_ready & out_eop.
- Counter arithmetic: all counters are 32-bit unsigned and wrap from 0xFFFFFFFF to 0.
- Reset values:
  - FSM state = IDLE, grant = 0, last = NUM_IN-1, so input 0 wins first.
  - out_valid=0; out_data, out_sop, out_eop, out_empty = 0.
  - All counters = 0; in_ready = 0 during Rst.
- Reset mid-packet: the partial packet is abandoned and no EOP is emitted. Downstream recovery is out of this block's scope.

## Timing
- Latency from input acceptance to out_valid: 1 cycle.
- One bubble cycle per packet for the IDLE grant.
- Throughput: a single-beat packet stream reaches 50% of cycles; long packets approach 100%.
- Full throughput mid-packet: with out_ready held at 1, one beat is accepted every cycle.
- Backpressure: out_ready=0 with out_valid=1 forces in_ready[grant]=0 in the same cycle. This path is combinational from out_ready.
- Simultaneous eop acceptance and new candidates: the grant for the next packet is decided in the following cycle (IDLE).
- Fairness: with all channels continuously offering packets, grants rotate 0,1,…,NUM_IN-1,0.

## Configuration
- PKT_MUX_STATS_EN defined: stat_in_pkt, stat_out_pkt and stat_err count as specified above.
- PKT_MUX_STATS_EN undefined:
  - Counter registers are not instantiated.
  - stat_* ports are tied to 0.
  - Data-path behaviour is identical, including orphan draining.

## Structure
- Package pkt_mux_pkg holds:
  - the FSM state enum (IDLE, BUSY);
  - STAT_W = 32;
  - the MAX_NUM_IN = 16 bound.
- Sub-module rr_arbiter (parameter N):
  - inputs: req[N], last index;
  - outputs: one-hot gnt, encoded index, any.
  - Purely combinational, so it can be reused by future N-way blocks.

## Test plan
- Reset: hold Rst 3 cycles with all inputs valid → all outputs 0 and in_ready=0; first grant after release goes to input 0.
- Fairness: NUM_IN=4, every channel offers continuous 2-beat packets, out_ready=1 → output packet order 0,1,2,3,0,1; each stat_in_pkt=2 after 8 packets; stat_out_pkt=8.
- Backpressure: 4-beat packet on input 2 with out_ready toggling 1,0,1,0 → 4 beats are delivered intact and in order, with no duplication or loss, and sop/eop on beats 1 and 4.
- Almost-full: out_almost_full=1 before an SOP arrives → no grant; raised mid-packet on a 6-beat packet → all 6 beats complete; a new grant occurs only after it deasserts.
- Orphan drain: input 1 presents 3 valid beats with sop=0 while IDLE → all 3 are consumed and none appear at the output; stat_err=3. Repeat with the macro undefined → stat_err=0 and draining is unchanged.
- Wrap/reset mid-packet: force stat_out_pkt to 0xFFFFFFFF, deliver one packet → counter reads 0. Assert Rst on beat 2 of a 5-beat packet → out_valid=0 on the next cycle and the FSM returns to IDLE.

Source files
------------

// File: rtl/pkt_mux_avlstrm_n_pkg.sv
// Shared types and constants for the N-input Avalon-ST packet multiplexer.
package pkt_mux_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    localparam int STAT_W     = 32;
    localparam int MAX_NUM_IN = 16;

    function automatic int empty_w(input int data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/pkt_mux_avlstrm_n_if.sv
// Avalon-ST bundle of LANES parallel streams; the mux uses an N-lane sink side
// and a 1-lane source side.
interface pkt_mux_avlstrm_n_if #(
    parameter int LANES  = 1,
    parameter int DATA_W = 512
);
    localparam int EMPTY_W = $clog2(DATA_W / 8);

    logic [LANES-1:0]         valid;
    logic [LANES-1:0]         ready;
    logic [LANES-1:0]         sop;
    logic [LANES-1:0]         eop;
    logic [LANES*DATA_W-1:0]  data;
    logic [LANES*EMPTY_W-1:0] empty;

    modport master (output valid, data, sop, eop, empty, input ready);
    modport slave  (input valid, data, sop, eop, empty, output ready);

endinterface

// File: rtl/pkt_mux_avlstrm_n_rr_arbiter.sv
// Combinational round-robin arbiter: searches last+1, last+2, ... modulo N and
// returns the first requester as one-hot and encoded index.
module rr_arbiter #(
    parameter  int N     = 4,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] last_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    always_comb begin
        int k;
        gnt_o = '0;
        idx_o = '0;
        any_o = |req_i;
        k     = 0;
        // Walk from lowest to highest priority so the last hit wins.
        for (int i = N; i >= 1; i--) begin
            k = int'(last_i) + i;
            if (k >= N) k = k - N;
            if (req_i[k]) begin
                gnt_o    = '0;
                gnt_o[k] = 1'b1;
                idx_o    = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/pkt_mux_avlstrm_n.sv
// N-input packet-atomic round-robin Avalon-ST mux with registered output.
// Per-channel/output/error packet counters are built only with PKT_MUX_STATS_EN.
module pkt_mux_avlstrm_n
    import pkt_mux_pkg::*;
#(
    parameter  int NUM_IN  = 4,
    parameter  int DATA_W  = 512,
    localparam int EMPTY_W = $clog2(DATA_W / 8)
) (
    input  logic                     Clk,
    input  logic                     Rst,
    pkt_mux_avlstrm_n_if.slave       in_if,
    pkt_mux_avlstrm_n_if.master      out_if,
    input  logic                     out_almost_full,
    output logic [NUM_IN*STAT_W-1:0] stat_in_pkt,
    output logic [STAT_W-1:0]        stat_out_pkt,
    output logic [STAT_W-1:0]        stat_err
);

    localparam int IDX_W = $clog2(NUM_IN);

    if (NUM_IN < 2 || NUM_IN > MAX_NUM_IN) begin : g_bad_num_in
        $error("pkt_mux_avlstrm_n: NUM_IN out of range");
    end

    state_e              state_q;
    logic [IDX_W-1:0]    grant_q;
    logic [IDX_W-1:0]    last_q;
    logic [NUM_IN-1:0]   grant_oh_q;
    logic                out_valid_q;
    logic                out_sop_q;
    logic                out_eop_q;
    logic [DATA_W-1:0]   out_data_q;
    logic [EMPTY_W-1:0]  out_empty_q;

    logic [NUM_IN-1:0]   cand;
    logic [NUM_IN-1:0]   orphan;
    logic [NUM_IN-1:0]   arb_gnt;
    logic [IDX_W-1:0]    arb_idx;
    logic                arb_any;
    logic                grant_fire;
    logic                accept_ok;
    logic                beat_acc;
    logic                g_valid;
    logic                g_eop;

    assign cand   = in_if.valid & in_if.sop;
    assign orphan = in_if.valid & ~in_if.sop;

    rr_arbiter #(.N(NUM_IN)) u_arb (
        .req_i  (cand),
        .last_i (last_q),
        .gnt_o  (arb_gnt),
        .idx_o  (arb_idx),
        .any_o  (arb_any)
    );

    assign grant_fire = (state_q == IDLE) && arb_any && !out_almost_full;
    assign accept_ok  = !out_valid_q || out_if.ready[0];
    assign g_valid    = in_if.valid[grant_q];
    assign g_eop      = in_if.eop[grant_q];
    assign beat_acc   = (state_q == BUSY) && accept_ok && g_valid;

    // IDLE only drains non-SOP beats; SOP beats wait for the grant cycle.
    always_comb begin
        in_if.ready = '0;
        if (!Rst) begin
            if (state_q == IDLE) in_if.ready = orphan;
            else                 in_if.ready = grant_oh_q & {NUM_IN{accept_ok}};
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            grant_oh_q  <= NUM_IN'(1);
            last_q      <= IDX_W'(NUM_IN - 1);
            out_valid_q <= 1'b0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            out_data_q  <= '0;
            out_empty_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (grant_fire) begin
                    grant_q    <= arb_idx;
                    grant_oh_q <= arb_gnt;
                    last_q     <= arb_idx;
                    state_q    <= BUSY;
                end
                BUSY: if (beat_acc && g_eop) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase

            if (beat_acc) begin
                out_valid_q <= 1'b1;
                out_sop_q   <= in_if.sop[grant_q];
                out_eop_q   <= g_eop;
                out_data_q  <= in_if.data[grant_q*DATA_W +: DATA_W];
                out_empty_q <= in_if.empty[grant_q*EMPTY_W +: EMPTY_W];
            end else if (out_if.ready[0]) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_if.valid = out_valid_q;
    assign out_if.sop   = out_sop_q;
    assign out_if.eop   = out_eop_q;
    assign out_if.data  = out_data_q;
    assign out_if.empty = out_empty_q;

`ifdef PKT_MUX_STATS_EN
    logic [NUM_IN-1:0][STAT_W-1:0] stat_in_q;
    logic [STAT_W-1:0]             stat_out_q;
    logic [STAT_W-1:0]             stat_err_q;
    logic                          drain;

    // Several channels draining together still count as one error event.
    assign drain = (state_q == IDLE) && (|orphan);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            stat_in_q  <= '0;
            stat_out_q <= '0;
            stat_err_q <= '0;
        end else begin
            if (beat_acc && g_eop)
                stat_in_q[grant_q] <= stat_in_q[grant_q] + STAT_W'(1);
            if (out_valid_q && out_if.ready[0] && out_eop_q)
                stat_out_q <= stat_out_q + STAT_W'(1);
            if (drain)
                stat_err_q <= stat_err_q + STAT_W'(1);
        end
    end

    assign stat_in_pkt  = stat_in_q;
    assign stat_out_pkt = stat_out_q;
    assign stat_err     = stat_err_q;
`else
    assign stat_in_pkt  = '0;
    assign stat_out_pkt = '0;
    assign stat_err     = '0;
`endif

endmodule
